regcfg_shadow: RTL and testbench
================================

Name: regcfg_shadow

Overview:
- Parametrised configuration register block for the HWPE matrix-MAC engine.
- Configuration is written by custom CPU instructions into a shadow set. On a MatrixMac start, the shadow set is committed to an active set that drives the engine.
- While the engine is busy, one further start is queued with its own configuration snapshot. A third start back-pressures the CPU.
- Also holds a parametrised feature-map base-address register file with pair writes and NRD read ports.

Parameters:
- DATA_W, 32, width of rs1_data/rs2_data.
- FMEM_AW, `FMEM_ADDR_WIDTH, width of a feature-map base address.
- NUM_BASE, 8, number of base-address registers; power of two, 2..32.
- IDX_W, $clog2(NUM_BASE), base-address index width.
- NRD, 2, number of base-address read ports.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- write_fmap_addrreg  in  1  write base[rd] = rs1_data and base[rd+1] = rs2_data.
- write_cfgreg  in  1  write shadow cfg0 = rs1_data and cfg1 = rs2_data.
- matrixmac_st  in  1  start request; rs1_data = {W_count, H_count}, rs2_data = {W_stride, H_stride}.
- rd  in  5  destination index; low IDX_W bits used.
- rs1_data  in  DATA_W  operand 1.
- rs2_data  in  DATA_W  operand 2.
- st_stall  out  1  combinational; start cannot be accepted this cycle.
- engine_start  out  1  registered one-cycle pulse to the engine.
- engine_done  in  1  one-cycle pulse from the engine; current job finished.
- busy  out  1  a job is running (state != IDLE).
- pending  out  1  a queued job exists (state == RUN_PEND).
- Conv_W_offset, Conv_CH_count  out  16 each  active cfg0[31:16] and cfg0[15:0].
- Kernel_size 4, Data_type 2, Layer_type 1, Kernel_333 1, AccReg_shift 5, K_count 10  out  active cfg1 fields at bits [3:0], [5:4], [6], [7], [12:8], [22:13].
- W_count, H_count, W_stride, H_stride  out  16 each  active job dimensions.
- baseaddr_ra  in  NRD*IDX_W  packed read indices.
- baseaddr_rd  out  NRD*FMEM_AW  packed read data; combinational from the register file.

Behaviour:
- Reset:
  - All shadow, pending and active registers = 0; base file = 0.
  - State = IDLE; engine_start = 0; st_stall = 0.
  - Reset mid-job abandons the job and any queued job.
- Register file writes:
  - Pair write goes to base[idx] and base[(idx+1) mod NUM_BASE]; wrap-around is required (idx = NUM_BASE-1 writes base[0] with rs2_data).
  - rd[4:IDX_W] are ignored.
  - A read in the same cycle as a write returns the old value; the new value is visible the next cycle.
  - Base-file writes are never shadowed.
- Shadow cfg: write_cfgreg updates shadow cfg0/cfg1 only. Active outputs change only at commit.
- FSM states: IDLE, RUN, RUN_PEND.
  - IDLE & matrixmac_st: active cfg <= shadow cfg; active dims <= rs data; engine_start = 1 next cycle; go to RUN.
  - RUN & matrixmac_st & !engine_done: pending cfg <= shadow cfg; pending dims <= rs data; go to RUN_PEND.
  - RUN & engine_done & !matrixmac_st: go to IDLE.
  - RUN & engine_done & matrixmac_st: commit directly as from IDLE; engine_start pulses; stay in RUN.
  - RUN_PEND & engine_done: active <= pending; engine_start pulses; go to RUN.
  - RUN_PEND & matrixmac_st: st_stall = 1 and the request is ignored. The CPU holds the request. The stall is dropped in the same cycle engine_done arrives; the held start is then queued while the pending job is promoted, and the state stays RUN_PEND.
- engine_done in IDLE is ignored.
- Same-cycle write_cfgreg & matrixmac_st: the start captures the pre-write shadow; the write lands in shadow only.
- Latency: engine_start is asserted exactly 1 cycle after the accepting edge. Active outputs are valid in that same cycle.

Decomposition:
- Package hwpe_cfg_pkg:
  - FSM state enum.
  - cfg1 field LSB/width constants.
  - Typedef for the packed cfg/dims record (cfg0, cfg1, four dims) used for the shadow, pending and active copies.
- Sub-module regcfg_basefile: parametrised NUM_BASE x FMEM_AW register file with wrapped pair write, async reset and NRD combinational read ports.

Test Plan:
- Reset, then write_fmap_addrreg rd=7, rs1=0x100, rs2=0x200 -> base[7]=0x100, base[0]=0x200 (wrap); read in the write cycle returns 0.
- write_cfgreg cfg1=0x0004_1A35, then start rs1=0x0020_0010 -> next cycle engine_start=1, Kernel_size=5, Data_type=3, AccReg_shift=0x1A>>... per fields, K_count=0x20, W_count=0x20, H_count=0x10.
- During RUN, write cfg1 Kernel_size=3, issue start -> pending=1, Kernel_size stays 5; engine_done -> one cycle later Kernel_size=3 and engine_start=1.
- In RUN_PEND, hold matrixmac_st -> st_stall=1 each cycle until engine_done; on that edge the queued job is promoted and the held start is queued (pending stays 1).
- In RUN, same-cycle engine_done & matrixmac_st -> engine_start next cycle, state stays RUN, pending=0.
- Assert rst in RUN_PEND -> all outputs 0, busy=0, pending=0 immediately (asynchronous), no engine_start after release.

Source files
------------

// File: rtl/hwpe_cfg_pkg.sv
// Shared types and field layout for the matrix-MAC configuration block.
`ifndef FMEM_ADDR_WIDTH
`define FMEM_ADDR_WIDTH 16
`endif

package hwpe_cfg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUN      = 2'd1,
        ST_RUN_PEND = 2'd2
    } state_e;

    localparam int unsigned CFG_W        = 32;
    localparam int unsigned DIM_W        = 16;

    localparam int unsigned KSIZE_LSB    = 0;
    localparam int unsigned KSIZE_W      = 4;
    localparam int unsigned DTYPE_LSB    = 4;
    localparam int unsigned DTYPE_W      = 2;
    localparam int unsigned LTYPE_LSB    = 6;
    localparam int unsigned K333_LSB     = 7;
    localparam int unsigned ACCSH_LSB    = 8;
    localparam int unsigned ACCSH_W      = 5;
    localparam int unsigned KCNT_LSB     = 13;
    localparam int unsigned KCNT_W       = 10;

    // One complete job description: shadow, pending and active copies share it.
    typedef struct packed {
        logic [CFG_W-1:0] cfg0;
        logic [CFG_W-1:0] cfg1;
        logic [DIM_W-1:0] w_count;
        logic [DIM_W-1:0] h_count;
        logic [DIM_W-1:0] w_stride;
        logic [DIM_W-1:0] h_stride;
    } job_cfg_t;

endpackage

// File: rtl/regcfg_basefile.sv
// Feature-map base-address register file: wrapped pair write, NRD async read ports.
module regcfg_basefile #(
    parameter int unsigned FMEM_AW  = 16,
    parameter int unsigned NUM_BASE = 8,
    parameter int unsigned IDX_W    = $clog2(NUM_BASE),
    parameter int unsigned NRD      = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   we,
    input  logic [IDX_W-1:0]       idx,
    input  logic [FMEM_AW-1:0]     wdata_lo,
    input  logic [FMEM_AW-1:0]     wdata_hi,
    input  logic [NRD*IDX_W-1:0]   ra,
    output logic [NRD*FMEM_AW-1:0] rdata
);

    logic [NUM_BASE-1:0][FMEM_AW-1:0] base_q;
    logic [NUM_BASE-1:0][FMEM_AW-1:0] base_d;
    logic [IDX_W-1:0]                 idx_hi;

    // Upper index wraps naturally because NUM_BASE is a power of two.
    assign idx_hi = idx + IDX_W'(1);

    // Next-state of the file: pair write to idx and idx+1.
    always_comb begin
        base_d = base_q;
        if (we) begin
            base_d[idx]    = wdata_lo;
            base_d[idx_hi] = wdata_hi;
        end
    end

    // Storage with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base_q <= '0;
        end else begin
            base_q <= base_d;
        end
    end

    // Read ports see the pre-write contents during a write cycle.
    always_comb begin
        rdata = '0;
        for (int unsigned i = 0; i < NRD; i++) begin
            rdata[i*FMEM_AW +: FMEM_AW] = base_q[ra[i*IDX_W +: IDX_W]];
        end
    end

endmodule

// File: rtl/regcfg_shadow.sv
// Shadowed configuration registers with one-deep start queue for the matrix-MAC engine.
module regcfg_shadow
    import hwpe_cfg_pkg::*;
#(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned FMEM_AW  = `FMEM_ADDR_WIDTH,
    parameter int unsigned NUM_BASE = 8,
    parameter int unsigned IDX_W    = $clog2(NUM_BASE),
    parameter int unsigned NRD      = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   write_fmap_addrreg,
    input  logic                   write_cfgreg,
    input  logic                   matrixmac_st,
    input  logic [4:0]             rd,
    input  logic [DATA_W-1:0]      rs1_data,
    input  logic [DATA_W-1:0]      rs2_data,
    output logic                   st_stall,
    output logic                   engine_start,
    input  logic                   engine_done,
    output logic                   busy,
    output logic                   pending,
    output logic [15:0]            Conv_W_offset,
    output logic [15:0]            Conv_CH_count,
    output logic [3:0]             Kernel_size,
    output logic [1:0]             Data_type,
    output logic                   Layer_type,
    output logic                   Kernel_333,
    output logic [4:0]             AccReg_shift,
    output logic [9:0]             K_count,
    output logic [15:0]            W_count,
    output logic [15:0]            H_count,
    output logic [15:0]            W_stride,
    output logic [15:0]            H_stride,
    input  logic [NRD*IDX_W-1:0]   baseaddr_ra,
    output logic [NRD*FMEM_AW-1:0] baseaddr_rd
);

    state_e          state_q, state_d;
    job_cfg_t        shadow_q, shadow_d;
    job_cfg_t        pend_q, pend_d;
    job_cfg_t        act_q, act_d;
    job_cfg_t        new_job_c;
    logic            engine_start_q, engine_start_d;
    logic            busy_q, busy_d;
    logic            pending_q, pending_d;
    logic [31:0]     rs1_w;
    logic [31:0]     rs2_w;
    logic            unused_rd_hi;

    assign rs1_w = 32'(rs1_data);
    assign rs2_w = 32'(rs2_data);
    assign unused_rd_hi = ^rd;

    regcfg_basefile #(
        .FMEM_AW  (FMEM_AW),
        .NUM_BASE (NUM_BASE),
        .IDX_W    (IDX_W),
        .NRD      (NRD)
    ) u_basefile (
        .clk      (clk),
        .rst      (rst),
        .we       (write_fmap_addrreg),
        .idx      (rd[IDX_W-1:0]),
        .wdata_lo (FMEM_AW'(rs1_data)),
        .wdata_hi (FMEM_AW'(rs2_data)),
        .ra       (baseaddr_ra),
        .rdata    (baseaddr_rd)
    );

    // Start cannot be taken while a job is already queued, unless the running job retires now.
    assign st_stall = (state_q == ST_RUN_PEND) && matrixmac_st && !engine_done;

    // Job snapshot from the pre-write shadow cfg plus this cycle's operand dims.
    always_comb begin
        new_job_c          = shadow_q;
        new_job_c.w_count  = rs1_w[31:16];
        new_job_c.h_count  = rs1_w[15:0];
        new_job_c.w_stride = rs2_w[31:16];
        new_job_c.h_stride = rs2_w[15:0];
    end

    // Next-state: shadow update, job acceptance, queueing and promotion.
    always_comb begin
        state_d        = state_q;
        shadow_d       = shadow_q;
        pend_d         = pend_q;
        act_d          = act_q;
        engine_start_d = 1'b0;

        if (write_cfgreg) begin
            shadow_d.cfg0 = rs1_w;
            shadow_d.cfg1 = rs2_w;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (matrixmac_st) begin
                    act_d          = new_job_c;
                    engine_start_d = 1'b1;
                    state_d        = ST_RUN;
                end
            end
            ST_RUN: begin
                if (engine_done && matrixmac_st) begin
                    act_d          = new_job_c;
                    engine_start_d = 1'b1;
                end else if (engine_done) begin
                    state_d = ST_IDLE;
                end else if (matrixmac_st) begin
                    pend_d  = new_job_c;
                    state_d = ST_RUN_PEND;
                end
            end
            ST_RUN_PEND: begin
                if (engine_done) begin
                    act_d          = pend_q;
                    engine_start_d = 1'b1;
                    if (matrixmac_st) begin
                        pend_d = new_job_c;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d    = (state_d != ST_IDLE);
        pending_d = (state_d == ST_RUN_PEND);
    end

    // All control and configuration state, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            shadow_q       <= '0;
            pend_q         <= '0;
            act_q          <= '0;
            engine_start_q <= 1'b0;
            busy_q         <= 1'b0;
            pending_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            shadow_q       <= shadow_d;
            pend_q         <= pend_d;
            act_q          <= act_d;
            engine_start_q <= engine_start_d;
            busy_q         <= busy_d;
            pending_q      <= pending_d;
        end
    end

    assign engine_start  = engine_start_q;
    assign busy          = busy_q;
    assign pending       = pending_q;
    assign Conv_W_offset = act_q.cfg0[31:16];
    assign Conv_CH_count = act_q.cfg0[15:0];
    assign Kernel_size   = act_q.cfg1[KSIZE_LSB +: KSIZE_W];
    assign Data_type     = act_q.cfg1[DTYPE_LSB +: DTYPE_W];
    assign Layer_type    = act_q.cfg1[LTYPE_LSB];
    assign Kernel_333    = act_q.cfg1[K333_LSB];
    assign AccReg_shift  = act_q.cfg1[ACCSH_LSB +: ACCSH_W];
    assign K_count       = act_q.cfg1[KCNT_LSB +: KCNT_W];
    assign W_count       = act_q.w_count;
    assign H_count       = act_q.h_count;
    assign W_stride      = act_q.w_stride;
    assign H_stride      = act_q.h_stride;

endmodule

// File: tb/tb_regcfg_shadow.sv
// Self-checking bench for regcfg_shadow: directed vector table, reset sequence, random vs job-queue model.
module tb_regcfg_shadow;

    logic        clk = 1'b0;
    logic        rst;
    logic        write_fmap_addrreg, write_cfgreg, matrixmac_st, engine_done;
    logic [4:0]  rd;
    logic [31:0] rs1_data, rs2_data;
    logic        st_stall, engine_start, busy, pending;
    logic [15:0] Conv_W_offset, Conv_CH_count, W_count, H_count, W_stride, H_stride;
    logic [3:0]  Kernel_size;
    logic [1:0]  Data_type;
    logic        Layer_type, Kernel_333;
    logic [4:0]  AccReg_shift;
    logic [9:0]  K_count;
    logic [5:0]  baseaddr_ra;
    logic [31:0] baseaddr_rd;

    always #5 clk = ~clk;

    regcfg_shadow dut (
        .clk(clk), .rst(rst),
        .write_fmap_addrreg(write_fmap_addrreg), .write_cfgreg(write_cfgreg),
        .matrixmac_st(matrixmac_st), .rd(rd), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .st_stall(st_stall), .engine_start(engine_start), .engine_done(engine_done),
        .busy(busy), .pending(pending),
        .Conv_W_offset(Conv_W_offset), .Conv_CH_count(Conv_CH_count),
        .Kernel_size(Kernel_size), .Data_type(Data_type), .Layer_type(Layer_type),
        .Kernel_333(Kernel_333), .AccReg_shift(AccReg_shift), .K_count(K_count),
        .W_count(W_count), .H_count(H_count), .W_stride(W_stride), .H_stride(H_stride),
        .baseaddr_ra(baseaddr_ra), .baseaddr_rd(baseaddr_rd)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model: a running job plus a FIFO of waiting jobs
    typedef struct {
        logic [31:0] cfg0, cfg1;
        logic [15:0] w, h, ws, hs;
    } job_t;

    job_t        m_shadow, m_act;
    job_t        m_q[$];
    bit          m_running, m_start;
    logic [15:0] m_base[8];

    function automatic logic [118:0] expand(input job_t j);
        return {j.cfg0[31:16], j.cfg0[15:0], j.cfg1[3:0], j.cfg1[5:4], j.cfg1[6], j.cfg1[7],
                j.cfg1[12:8], j.cfg1[22:13], j.w, j.h, j.ws, j.hs};
    endfunction

    logic [118:0] dut_vec;
    assign dut_vec = {Conv_W_offset, Conv_CH_count, Kernel_size, Data_type, Layer_type, Kernel_333,
                      AccReg_shift, K_count, W_count, H_count, W_stride, H_stride};

    task automatic model_reset();
        m_shadow = '{default: '0};
        m_act    = '{default: '0};
        m_q.delete();
        m_running = 0;
        m_start   = 0;
        for (int i = 0; i < 8; i++) m_base[i] = '0;
    endtask

    // ---------------- directed vector table
    typedef struct {
        logic        wfa, wcfg, st, done;
        logic [4:0]  rd;
        logic [31:0] rs1, rs2;
        logic [2:0]  ra0;
        logic        x_stall;
        logic [15:0] x_rd0;
        logic        x_start, x_busy, x_pend;
        logic [3:0]  x_ks;
        logic [15:0] x_wc;
    } vec_t;

    function automatic vec_t mk(input int wfa, input int wcfg, input int st, input int done,
                                input int rdi, input int rs1, input int rs2, input int ra0,
                                input int xs, input int xrd, input int xst, input int xb,
                                input int xp, input int xks, input int xwc);
        vec_t v;
        v.wfa = 1'(wfa); v.wcfg = 1'(wcfg); v.st = 1'(st); v.done = 1'(done);
        v.rd = 5'(rdi); v.rs1 = 32'(rs1); v.rs2 = 32'(rs2); v.ra0 = 3'(ra0);
        v.x_stall = 1'(xs); v.x_rd0 = 16'(xrd); v.x_start = 1'(xst); v.x_busy = 1'(xb);
        v.x_pend = 1'(xp); v.x_ks = 4'(xks); v.x_wc = 16'(xwc);
        return v;
    endfunction

    vec_t vecs[21];

    task automatic drive_idle();
        write_fmap_addrreg = 0; write_cfgreg = 0; matrixmac_st = 0; engine_done = 0;
        rd = '0; rs1_data = '0; rs2_data = '0; baseaddr_ra = '0;
    endtask

    initial begin
        drive_idle();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset_busy", 128'(busy), 128'(0));
        chk("reset_start", 128'(engine_start), 128'(0));
        chk("reset_outs", 128'(dut_vec), 128'(0));

        //         wfa wcfg st done rd  rs1          rs2          ra0 stall rd0    start busy pend ks wc
        vecs[0]  = mk(1, 0, 0, 0, 7,  32'h100,      32'h200,      7,  0, 16'h0,   0, 0, 0, 0, 16'h0);
        vecs[1]  = mk(0, 0, 0, 0, 0,  0,            0,            0,  0, 16'h200, 0, 0, 0, 0, 16'h0);
        vecs[2]  = mk(0, 0, 0, 0, 0,  0,            0,            7,  0, 16'h100, 0, 0, 0, 0, 16'h0);
        vecs[3]  = mk(0, 1, 0, 0, 0,  0,            32'h0004_1A35, 0, 0, 16'h200, 0, 0, 0, 0, 16'h0);
        vecs[4]  = mk(0, 0, 1, 0, 0,  32'h0020_0010, 32'h0001_0002, 0, 0, 16'h200, 1, 1, 0, 5, 16'h20);
        vecs[5]  = mk(0, 0, 0, 0, 0,  0,            0,            0,  0, 16'h200, 0, 1, 0, 5, 16'h20);
        vecs[6]  = mk(0, 1, 0, 0, 0,  0,            32'h0004_1A33, 0, 0, 16'h200, 0, 1, 0, 5, 16'h20);
        vecs[7]  = mk(0, 0, 1, 0, 0,  32'h0030_0008, 32'h0, 0,        0, 16'h200, 0, 1, 1, 5, 16'h20);
        vecs[8]  = mk(0, 0, 1, 0, 0,  32'h0040_0004, 32'h0, 0,        1, 16'h200, 0, 1, 1, 5, 16'h20);
        vecs[9]  = mk(0, 0, 1, 0, 0,  32'h0040_0004, 32'h0, 0,        1, 16'h200, 0, 1, 1, 5, 16'h20);
        vecs[10] = mk(0, 0, 1, 1, 0,  32'h0040_0004, 32'h0, 0,        0, 16'h200, 1, 1, 1, 3, 16'h30);
        vecs[11] = mk(0, 0, 0, 0, 0,  0,            0,            0,  0, 16'h200, 0, 1, 1, 3, 16'h30);
        vecs[12] = mk(0, 0, 0, 1, 0,  0,            0,            0,  0, 16'h200, 1, 1, 0, 3, 16'h40);
        vecs[13] = mk(0, 1, 1, 1, 0,  32'h0050_0002, 32'h0004_1A37, 0, 0, 16'h200, 1, 1, 0, 3, 16'h50);
        vecs[14] = mk(0, 0, 0, 0, 0,  0,            0,            0,  0, 16'h200, 0, 1, 0, 3, 16'h50);
        vecs[15] = mk(0, 0, 0, 1, 0,  0,            0,            0,  0, 16'h200, 0, 0, 0, 3, 16'h50);
        vecs[16] = mk(0, 0, 0, 1, 0,  0,            0,            0,  0, 16'h200, 0, 0, 0, 3, 16'h50);
        vecs[17] = mk(0, 0, 1, 0, 0,  32'h0060_0001, 32'h0, 0,        0, 16'h200, 1, 1, 0, 7, 16'h60);
        vecs[18] = mk(0, 0, 1, 0, 0,  32'h0070_0001, 32'h0, 0,        0, 16'h200, 0, 1, 1, 7, 16'h60);
        vecs[19] = mk(1, 0, 0, 0, 26, 32'hAAA,      32'hBBB,      2,  0, 16'h0,   0, 1, 1, 7, 16'h60);
        vecs[20] = mk(0, 0, 0, 0, 0,  0,            0,            3,  0, 16'hBBB, 0, 1, 1, 7, 16'h60);

        for (int i = 0; i < 21; i++) begin
            write_fmap_addrreg = vecs[i].wfa; write_cfgreg = vecs[i].wcfg;
            matrixmac_st = vecs[i].st; engine_done = vecs[i].done;
            rd = vecs[i].rd; rs1_data = vecs[i].rs1; rs2_data = vecs[i].rs2;
            baseaddr_ra = {3'd0, vecs[i].ra0};
            #1;
            chk($sformatf("vec%0d_stall", i), 128'(st_stall), 128'(vecs[i].x_stall));
            chk($sformatf("vec%0d_rd0", i), 128'(baseaddr_rd[15:0]), 128'(vecs[i].x_rd0));
            @(posedge clk); #1;
            chk($sformatf("vec%0d_start", i), 128'(engine_start), 128'(vecs[i].x_start));
            chk($sformatf("vec%0d_busy", i), 128'(busy), 128'(vecs[i].x_busy));
            chk($sformatf("vec%0d_pend", i), 128'(pending), 128'(vecs[i].x_pend));
            chk($sformatf("vec%0d_ksize", i), 128'(Kernel_size), 128'(vecs[i].x_ks));
            chk($sformatf("vec%0d_wcount", i), 128'(W_count), 128'(vecs[i].x_wc));
        end
        chk("first_job_dtype", 128'(Data_type), 128'(3));

        // Asynchronous reset while a job is running and another is queued.
        drive_idle();
        matrixmac_st = 1'b1;
        baseaddr_ra = {3'd0, 3'd7};
        #2 rst = 1'b1;
        #1;
        chk("arst_busy", 128'(busy), 128'(0));
        chk("arst_pending", 128'(pending), 128'(0));
        chk("arst_start", 128'(engine_start), 128'(0));
        chk("arst_stall", 128'(st_stall), 128'(0));
        chk("arst_outs", 128'(dut_vec), 128'(0));
        chk("arst_base", 128'(baseaddr_rd), 128'(0));
        matrixmac_st = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            chk("post_rst_start", 128'(engine_start), 128'(0));
            chk("post_rst_busy", 128'(busy), 128'(0));
        end

        // Random traffic against the job-queue model.
        model_reset();
        for (int c = 0; c < 2000; c++) begin
            logic        exp_stall;
            job_t        snap;
            logic [2:0]  ra0, ra1, idx;
            write_fmap_addrreg = ($urandom_range(3) == 0);
            write_cfgreg       = ($urandom_range(3) == 0);
            matrixmac_st       = ($urandom_range(2) == 0);
            engine_done        = ($urandom_range(3) == 0);
            rd                 = 5'($urandom);
            rs1_data           = $urandom;
            rs2_data           = $urandom;
            ra0 = 3'($urandom); ra1 = 3'($urandom);
            baseaddr_ra = {ra1, ra0};
            #1;
            exp_stall = matrixmac_st && m_running && (m_q.size() != 0) && !engine_done;
            chk("rnd_stall", 128'(st_stall), 128'(exp_stall));
            chk("rnd_rd", 128'(baseaddr_rd), 128'({m_base[ra1], m_base[ra0]}));

            snap = m_shadow;
            snap.w = rs1_data[31:16]; snap.h = rs1_data[15:0];
            snap.ws = rs2_data[31:16]; snap.hs = rs2_data[15:0];
            m_start = 0;
            if (engine_done && m_running) begin
                if (m_q.size() != 0) begin
                    m_act = m_q.pop_front();
                    m_start = 1;
                end else begin
                    m_running = 0;
                end
            end
            if (matrixmac_st && !exp_stall) begin
                if (!m_running) begin
                    m_act = snap; m_running = 1; m_start = 1;
                end else begin
                    m_q.push_back(snap);
                end
            end
            if (write_cfgreg) begin
                m_shadow.cfg0 = rs1_data; m_shadow.cfg1 = rs2_data;
            end
            if (write_fmap_addrreg) begin
                idx = rd[2:0];
                m_base[idx] = rs1_data[15:0];
                m_base[(idx + 1) % 8] = rs2_data[15:0];
            end

            @(posedge clk); #1;
            chk("rnd_start", 128'(engine_start), 128'(m_start));
            chk("rnd_busy", 128'(busy), 128'(m_running));
            chk("rnd_pend", 128'(pending), 128'(m_q.size() != 0));
            chk("rnd_outs", 128'(dut_vec), 128'(expand(m_act)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
